// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through receive FIFO.
// Sticky framing/overrun flags; bytes are popped via a valid/ready interface.
module uart_rx_fifo #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clear
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CW           = AW + 1;
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             rx_m, rx_s;
    logic             push_req, ferr_set;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             pop, push_ok, ovr_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        bit_d    = bit_q;
        sh_d     = sh_q;
        push_req = 1'b0;
        ferr_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push_req = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid & rd_ready;
    assign push_ok  = push_req & ((count_q < CW'(FIFO_DEPTH)) | pop);
    assign ovr_set  = push_req & ~push_ok;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= sh_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ferr_set)       frame_err <= 1'b1;
            else if (err_clear) frame_err <= 1'b0;
            if (ovr_set)        overrun   <= 1'b1;
            else if (err_clear) overrun   <= 1'b0;
        end
    end

    assign rd_data    = rd_valid ? mem[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 10 clocks per bit.
// Checks reset, timing, glitch rejection, framing, overrun and mid-frame reset.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [4:0] fifo_count;
    logic       frame_err;
    logic       overrun;
    logic       err_clear = 1'b0;

    int errors = 0;
    int checks = 0;

    uart_rx_fifo #(
        .CLOCK_FREQ(1_000_000),
        .BAUD_RATE (100_000),
        .FIFO_DEPTH(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .fifo_count(fifo_count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clear (err_clear)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(10);
        end
        rx = stop_bit;
        tick(10);
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
    endtask

    initial begin
        // 1. reset
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_data", 32'(rd_data), 32'h00);

        // 2. first frame and latency of rd_valid
        fork
            send_frame(8'hA5, 1'b1);
            begin
                tick(97);
                check("lat_before", 32'(rd_valid), 32'd0);
                tick(1);
                check("lat_at", 32'(rd_valid), 32'd1);
            end
        join
        check("a5_data", 32'(rd_data), 32'hA5);
        check("a5_count", 32'(fifo_count), 32'd1);
        pop_one();
        check("a5_pop_valid", 32'(rd_valid), 32'd0);
        check("a5_pop_count", 32'(fifo_count), 32'd0);

        // 3. short low glitch is ignored
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(20);
        check("glitch_count", 32'(fifo_count), 32'd0);
        check("glitch_ferr", 32'(frame_err), 32'd0);
        send_frame(8'h3C, 1'b1);
        check("3c_data", 32'(rd_data), 32'h3C);
        check("3c_count", 32'(fifo_count), 32'd1);
        pop_one();

        // 4. framing error then recovery
        send_frame(8'h55, 1'b0);
        tick(50);
        check("ferr_set", 32'(frame_err), 32'd1);
        check("ferr_count", 32'(fifo_count), 32'd0);
        rx = 1'b1;
        tick(5);
        send_frame(8'h12, 1'b1);
        check("12_data", 32'(rd_data), 32'h12);
        check("12_count", 32'(fifo_count), 32'd1);
        check("ferr_sticky", 32'(frame_err), 32'd1);
        pop_one();
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        check("ferr_clear", 32'(frame_err), 32'd0);

        // 5. overflow with no consumer
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
        check("ovf_count", 32'(fifo_count), 32'd16);
        check("ovf_flag", 32'(overrun), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_%0d", i), 32'(rd_data), 32'(i));
            pop_one();
        end
        check("drain_count", 32'(fifo_count), 32'd0);
        check("drain_valid", 32'(rd_valid), 32'd0);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        check("ovr_clear", 32'(overrun), 32'd0);

        // 6. full FIFO with pop during the 17th stop sample
        for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b1);
        check("full_count", 32'(fifo_count), 32'd16);
        check("full_ovr", 32'(overrun), 32'd0);
        fork
            send_frame(8'h30, 1'b1);
            begin
                tick(97);
                rd_ready = 1'b1;
                tick(1);
                rd_ready = 1'b0;
            end
        join
        check("pp_count", 32'(fifo_count), 32'd16);
        check("pp_ovr", 32'(overrun), 32'd0);
        check("pp_head", 32'(rd_data), 32'h21);

        // reset in the middle of a frame
        fork
            send_frame(8'h44, 1'b1);
            begin
                tick(40);
                rst = 1'b1;
            end
        join
        tick(2);
        rst = 1'b0;
        tick(1);
        check("mrst_count", 32'(fifo_count), 32'd0);
        check("mrst_valid", 32'(rd_valid), 32'd0);
        send_frame(8'h5A, 1'b1);
        check("5a_data", 32'(rd_data), 32'h5A);
        check("5a_count", 32'(fifo_count), 32'd1);
        check("5a_ferr", 32'(frame_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
